// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared ALU op codes and HI/LO sequencer state encoding.
// Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [3:0] ALU_DIV   = 4'd0;
    localparam logic [3:0] ALU_DIVU  = 4'd1;
    localparam logic [3:0] ALU_MULT  = 4'd2;
    localparam logic [3:0] ALU_MULTU = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } md_state_t;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_md_op(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_MULT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : md_iter_step
// Description : One combinational shift-add (multiply) or restoring-divide step.
// Revision    : 1.0
// ============================================================================
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    input  logic             is_div,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    always_comb begin
        w_sum  = {1'b0, acc} + (q[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        w_rem  = {acc, q[WIDTH-1]};
        w_fits = (w_rem >= {1'b0, operand});
        // When the divisor fits, the true difference is below 2^WIDTH.
        w_diff = w_rem[WIDTH-1:0] - operand;

        if (is_div) begin
            acc_next = w_fits ? w_diff : w_rem[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], w_fits};
        end else begin
            acc_next = w_sum[WIDTH:1];
            q_next   = {w_sum[0], q[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_sequencer
// Description : Multi-cycle HI/LO multiply/divide controller with pipeline stall.
// Revision    : 1.0
// ============================================================================
module mult_div_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mfhi,
    input  logic             mflo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic             r_done;

    logic             w_signed;
    logic             w_div;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    always_comb begin
        w_signed  = is_signed_md_op(op);
        w_div     = is_div_op(op);
        w_a_abs   = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        w_b_abs   = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;
        w_product = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
        // Divide by zero leaves |a| in the accumulator, so the remainder path
        // already reproduces src_a; only the quotient needs forcing.
        w_quot    = r_div_zero ? {WIDTH{1'b1}} : (r_neg_q ? -r_q : r_q);
        w_rem     = r_neg_r ? -r_acc : r_acc;
    end

    md_iter_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .acc      (r_acc),
        .q        (r_q),
        .operand  (r_operand),
        .is_div   (r_is_div),
        .acc_next (w_acc_next),
        .q_next   (w_q_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_operand  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && is_md_op(op)) begin
                        r_state    <= RUN;
                        r_count    <= '0;
                        r_acc      <= '0;
                        r_is_div   <= w_div;
                        r_q        <= w_div ? w_a_abs : w_b_abs;
                        r_operand  <= w_div ? w_b_abs : w_a_abs;
                        r_neg_q    <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        r_neg_r    <= w_signed && src_a[WIDTH-1];
                        r_div_zero <= w_div && (src_b == '0);
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_ITER) begin
                        r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_product[2*WIDTH-1:WIDTH];
                        r_lo <= w_product[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign stall   = busy & (mfhi | mflo | start);
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign rd_data = mfhi ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_sequencer
// Description : Directed vector table plus stall and mid-run reset sequences.
// Revision    : 1.0
// ============================================================================
module tb_mult_div_sequencer;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mfhi;
    logic        mflo;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int passed;
    int total;
    int lat;
    int stall_err;
    int busy_err;
    int hold_err;
    int early_done;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .mfhi    (mfhi),
        .mflo    (mflo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Caller is just after a rising edge; returns in the done cycle (or on timeout).
    task automatic issue_and_wait(input logic [3:0] o, input logic [31:0] a,
                                  input logic [31:0] b, output int n);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        n     = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end while (!done && n < 100);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 4'd0;
        src_a  = '0;
        src_b  = '0;
        mfhi   = 1'b0;
        mflo   = 1'b0;

        vecs[0]  = '{ALU_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{ALU_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{ALU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6]  = '{ALU_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
        vecs[7]  = '{ALU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{ALU_MULTU, 32'h12345678, 32'h100,      32'h00000012, 32'h34567800};
        vecs[9]  = '{ALU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{ALU_DIV,   32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[11] = '{ALU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[12] = '{ALU_MULTU, 32'd0,        32'd5,        32'h00000000, 32'h00000000};

        repeat (2) @(posedge clk);
        #1;
        check("reset_hi",    hi,          32'h0);
        check("reset_lo",    lo,          32'h0);
        check("reset_busy",  32'(busy),   32'h0);
        check("reset_stall", 32'(stall),  32'h0);
        check("reset_done",  32'(done),   32'h0);
        rst_n = 1'b1;

        // Illegal op code must not leave IDLE.
        @(posedge clk);
        #1;
        op    = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("badop_busy", 32'(busy), 32'h0);
        check("badop_done", 32'(done), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
            check($sformatf("vec%0d_busy", i),    32'(busy), 32'h0);
            check($sformatf("vec%0d_hi", i),      hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i),      lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_rd_lo", i),   rd_data, vecs[i].exp_lo);
            @(posedge clk);
            #1;
        end
        check("done_one_pulse", 32'(done), 32'h0);

        // Stall sequence: old HI/LO are those of the last table entry (0/0).
        op    = ALU_MULTU;
        src_a = 32'hFFFFFFFF;
        src_b = 32'd2;
        start = 1'b1;
        mfhi  = 1'b1;
        #1;
        check("issue_mfhi_nostall", 32'(stall), 32'h0);
        check("issue_mfhi_old_hi",  rd_data,    32'h0);
        stall_err  = 0;
        busy_err   = 0;
        hold_err   = 0;
        early_done = 0;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk);
            #1;
            start = (c == 8);
            if (c == 8) begin
                op    = ALU_DIVU;
                src_a = 32'd1000;
                src_b = 32'd3;
            end
            mfhi = (c >= 5);
            #1;
            if (stall !== (c >= 5)) stall_err++;
            if (busy !== 1'b1) busy_err++;
            if (hi !== 32'h0 || lo !== 32'h0) hold_err++;
            if (done !== 1'b0) early_done++;
        end
        check("seq_stall_pattern", 32'(stall_err),  32'd0);
        check("seq_busy_held",     32'(busy_err),   32'd0);
        check("seq_hilo_held",     32'(hold_err),   32'd0);
        check("seq_no_early_done", 32'(early_done), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        check("seq_done",        32'(done),  32'h1);
        check("seq_done_nostal", 32'(stall), 32'h0);
        check("seq_rd_new_hi",   rd_data,    32'h00000001);
        check("seq_new_lo",      lo,         32'hFFFFFFFE);
        mfhi = 1'b0;
        @(posedge clk);
        #2;
        check("seq_restart_ignored", 32'(busy), 32'h0);
        check("seq_hi_kept",         hi,        32'h00000001);
        check("seq_lo_kept",         lo,        32'hFFFFFFFE);

        // Reset in the middle of RUN, at the edge performing iteration 10.
        op    = ALU_MULT;
        src_a = 32'd7;
        src_b = 32'd9;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("rst_pre_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        mfhi  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_hi",    hi,         32'h0);
        check("rst_lo",    lo,         32'h0);
        rst_n = 1'b1;
        mfhi  = 1'b0;
        @(posedge clk);
        #1;
        issue_and_wait(ALU_MULT, 32'hFFFFFFF9, 32'd9, lat);
        check("post_rst_latency", 32'(lat), 32'd34);
        check("post_rst_hi",      hi,       32'hFFFFFFFF);
        check("post_rst_lo",      lo,       32'hFFFFFFC1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
